dual_diagonal_backsub_stream: RTL and testbench
===============================================

Name: dual_diagonal_backsub_stream

Overview:
Streaming dual-diagonal back-substitution for LDPC parity generation. Each block is processed as a running XOR: p[0] = seed ^ s[0], p[k] = p[k-1] ^ s[k].
This generalises the fixed-length, no-backpressure back-sub stage in four ways:
- runtime block length;
- per-block seed;
- ready/valid flow control on both sides;
- a last-word marker.
Sits between the syndrome/H-matrix multiply stage and the parity packer in the encoder.

Parameters:
WIDTH, 16, bits per word (one parity lane per bit).
MAX_WORDS, 64, maximum block length in words; must be >= 2.
CNT_W, $clog2(MAX_WORDS+1), width of length/counter fields (derived localparam, not overridden).

Ports:
i_clock  in  1  single clock; all logic on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_num_words  in  CNT_W  block length; sampled only on the first accepted word of a block.
i_seed  in  WIDTH  XOR seed; sampled with i_num_words on the first word of a block.
i_in_data  in  WIDTH  syndrome word.
i_in_valid  in  1  input word valid.
o_in_ready  out  1  block can accept a word this cycle.
o_out_data  out  WIDTH  parity word.
o_out_valid  out  1  output word valid.
o_out_last  out  1  qualifies o_out_valid; marks the final word of a block.
i_out_ready  in  1  downstream accepts the output.
o_busy  out  1  a block is partially consumed (word counter != 0).
o_err_len  out  1  sticky; an illegal length was sampled.

Behaviour:
- Reset (synchronous, i_reset=1 at a rising edge) clears every register:
  - outputs: o_out_valid=0, o_out_last=0, o_out_data=0, o_busy=0, o_err_len=0;
  - internals: accumulator=0, word counter=0.
  - o_in_ready is low while i_reset=1.
- Accept rule: accept = i_in_valid & o_in_ready.
  - o_in_ready = ~o_out_valid | i_out_ready (combinational; single output register, no skid).
  - o_in_ready must not depend combinationally on i_in_valid.
- Block start: an accept with counter==0.
  - Latch len = i_num_words.
  - If i_num_words==0 or i_num_words>MAX_WORDS: set o_err_len, use len=MAX_WORDS.
  - Effective previous value = i_seed, not the accumulator.
- Datapath on each accept:
  - p = (counter==0 ? i_seed : acc) ^ i_in_data;
  - acc <= p; o_out_data <= p; o_out_valid <= 1;
  - o_out_last <= (counter == len-1).
  - If last: counter <= 0. Otherwise counter <= counter+1.
- Latency: word accepted at edge t appears on the output at t (registered), visible for the cycle after t. Throughput is 1 word/clock when i_out_ready is held high.
- Output hold: while o_out_valid=1 and i_out_ready=0:
  - o_out_data and o_out_last are held stable;
  - o_in_ready=0, so no input is consumed.
- Output drain: if o_out_valid=1, i_out_ready=1 and there is no accept, o_out_valid <= 0 (o_out_last <= 0).
- Simultaneous output drain and new accept in the same cycle: the new word replaces the old one with no bubble.
- Back-to-back blocks: the word after a last word starts a new block in the next cycle. It re-samples i_num_words and i_seed; no idle cycle is required.
- len==1: every word is a block; o_out_last=1 on each; p = seed ^ s.
- Mid-block changes: i_num_words and i_seed are ignored mid-block.
- Input gaps: i_in_valid gaps mid-block are allowed; state is held.
- Reset mid-block: any partial block is discarded, the pending output is dropped, and the next accepted word starts a new block.
- Arithmetic: bitwise XOR only, no carries; counter saturation is impossible by construction (wraps to 0 at len).

Test Plan:
1. N=8, seed=0, eight words 0, continuous ready -> eight outputs of 0; o_out_last only on the 8th; o_busy low afterwards.
2. N=8, seed=0, inputs 37449,56173,28086,46811,56173,28086,46811,56173 -> outputs 37449,18724,9362,37449,18724,9362,37449,18724, one per clock; first output visible one clock after the first accept.
3. Same stream as scenario 2, with i_out_ready low for 3 cycles after the 2nd output -> o_in_ready low for those 3 cycles; output 18724 held stable; full sequence identical with no loss or duplication.
4. Back-to-back: block A (N=3, seed=0, inputs 1,2,4) then immediately block B (N=2, seed=0xFFFF, inputs 0x9249,0x0001).
   - A outputs 1,3,7, last on 7.
   - B outputs 0x6DB6 (28086), 0x6DB7, last on 0x6DB7.
   - No gap cycle between blocks.
5. i_num_words=0 on block start -> o_err_len=1 and stays 1 until reset; block runs MAX_WORDS=64 words with last on the 64th.
6. N=8, reset asserted after the 4th accept -> next cycle o_out_valid=0 and o_busy=0; a following N=2 block with inputs 5,6 outputs 5,3 with last on 3.

Source files
------------

// File: rtl/dual_diagonal_backsub_stream.sv
// Streaming dual-diagonal back-substitution for LDPC parity generation.
// Each block is a running XOR: p[0] = seed ^ s[0], p[k] = p[k-1] ^ s[k].
// Runtime block length and seed are sampled on the first word of a block.
// Ready/valid on both sides, with a single output register and no skid buffer.
module dual_diagonal_backsub_stream #(
    parameter  int WIDTH     = 16,
    parameter  int MAX_WORDS = 64,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_num_words,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_out_last,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_err_len
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    // Architectural state
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_err_len;

    // Per-word decode
    logic             w_in_ready;
    logic             w_accept;
    logic             w_first;
    logic             w_len_bad;
    logic [CNT_W-1:0] w_len_eff;
    logic [WIDTH-1:0] w_prev;
    logic [WIDTH-1:0] w_parity;
    logic             w_is_last;

    // The output register can take a new word when it is empty or being drained
    // this cycle; the input side never looks at i_in_valid here.
    assign w_in_ready = ~i_reset & (~r_out_valid | i_out_ready);
    assign w_accept   = i_in_valid & w_in_ready;

    // Block start is simply "counter at zero"; length and seed come straight
    // from the ports on that word, and from the latched copy afterwards.
    assign w_first   = (r_cnt == '0);
    assign w_len_bad = (i_num_words == '0) || (i_num_words > LP_MAX);

    // Effective length for this word: fresh sample at block start, latched otherwise
    always_comb begin
        w_len_eff = r_len;
        if (w_first) begin
            w_len_eff = w_len_bad ? LP_MAX : i_num_words;
        end
    end

    assign w_prev    = w_first ? i_seed : r_acc;
    assign w_parity  = w_prev ^ i_in_data;
    assign w_is_last = (r_cnt == (w_len_eff - LP_ONE));

    // Accumulator, word counter and latched length advance on every accept
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else if (w_accept) begin
            r_acc <= w_parity;
            if (w_first) begin
                r_len <= w_len_eff;
            end
            if (w_is_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + LP_ONE;
            end
        end
    end

    // Output register: load on accept, drop valid when drained without refill
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_parity;
            r_out_valid <= 1'b1;
            r_out_last  <= w_is_last;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // Sticky length error, set when an illegal length is sampled at block start
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_err_len <= 1'b0;
        end else if (w_accept && w_first && w_len_bad) begin
            r_err_len <= 1'b1;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_cnt != '0);
    assign o_err_len   = r_err_len;

endmodule

// File: tb/tb_dual_diagonal_backsub_stream.sv
// Directed bench for dual_diagonal_backsub_stream: hand-computed parity
// streams, stalls, back-to-back blocks, illegal length and mid-block reset.
module tb_dual_diagonal_backsub_stream;

    localparam int WIDTH     = 16;
    localparam int MAX_WORDS = 64;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    logic             clk = 1'b0;
    logic             i_reset;
    logic [CNT_W-1:0] i_num_words;
    logic [WIDTH-1:0] i_seed;
    logic [WIDTH-1:0] i_in_data;
    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] o_out_data;
    logic             o_out_valid;
    logic             o_out_last;
    logic             i_out_ready;
    logic             o_busy;
    logic             o_err_len;

    int checks   = 0;
    int failures = 0;

    dual_diagonal_backsub_stream #(
        .WIDTH    (WIDTH),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_num_words(i_num_words),
        .i_seed     (i_seed),
        .i_in_data  (i_in_data),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .o_out_data (o_out_data),
        .o_out_valid(o_out_valid),
        .o_out_last (o_out_last),
        .i_out_ready(i_out_ready),
        .o_busy     (o_busy),
        .o_err_len  (o_err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word with downstream ready, check it was accepted and what it produced
    task automatic push(input string tag, input logic [WIDTH-1:0] d, input int n,
                        input logic [WIDTH-1:0] seed, input logic [WIDTH-1:0] exp_d,
                        input logic exp_last);
        i_in_data   = d;
        i_num_words = CNT_W'(n);
        i_seed      = seed;
        i_in_valid  = 1'b1;
        i_out_ready = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(o_in_ready), 32'd1);
        tick();
        chk({tag, ".valid"}, 32'(o_out_valid), 32'd1);
        chk({tag, ".data"},  32'(o_out_data),  32'(exp_d));
        chk({tag, ".last"},  32'(o_out_last),  32'(exp_last));
    endtask

    // Stop offering input, let the output drain for one cycle
    task automatic idle();
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] s2 [8];
        logic [WIDTH-1:0] p2 [8];
        logic [WIDTH-1:0] model;

        s2 = '{16'd37449, 16'd56173, 16'd28086, 16'd46811,
               16'd56173, 16'd28086, 16'd46811, 16'd56173};
        p2 = '{16'd37449, 16'd18724, 16'd9362,  16'd37449,
               16'd18724, 16'd9362,  16'd37449, 16'd18724};

        i_reset     = 1'b1;
        i_num_words = '0;
        i_seed      = '0;
        i_in_data   = '0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        tick();
        tick();
        chk("rst.valid", 32'(o_out_valid), 32'd0);
        chk("rst.last",  32'(o_out_last),  32'd0);
        chk("rst.data",  32'(o_out_data),  32'd0);
        chk("rst.busy",  32'(o_busy),      32'd0);
        chk("rst.err",   32'(o_err_len),   32'd0);
        chk("rst.ready", 32'(o_in_ready),  32'd0);
        i_reset = 1'b0;
        tick();

        // 1: all-zero block
        for (int k = 0; k < 8; k++) begin
            push("s1", 16'h0000, 8, 16'h0000, 16'h0000, (k == 7));
            if (k < 7) chk("s1.busy", 32'(o_busy), 32'd1);
        end
        idle();
        chk("s1.busy_after",  32'(o_busy),      32'd0);
        chk("s1.valid_after", 32'(o_out_valid), 32'd0);

        // 2: reference stream; seed/len changes mid-block must be ignored
        for (int k = 0; k < 8; k++) begin
            push("s2", s2[k], (k == 0) ? 8 : 3, (k == 0) ? 16'h0000 : 16'h5A5A, p2[k], (k == 7));
        end
        idle();

        // 3: same stream, downstream stalls for 3 cycles after the 2nd output
        push("s3", s2[0], 8, 16'h0000, p2[0], 1'b0);
        push("s3", s2[1], 8, 16'h0000, p2[1], 1'b0);
        i_in_data   = s2[2];
        i_in_valid  = 1'b1;
        i_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("s3.stall_ready", 32'(o_in_ready), 32'd0);
            tick();
            chk("s3.hold_valid", 32'(o_out_valid), 32'd1);
            chk("s3.hold_data",  32'(o_out_data),  32'd18724);
            chk("s3.hold_last",  32'(o_out_last),  32'd0);
        end
        for (int k = 2; k < 8; k++) begin
            push("s3", s2[k], 8, 16'h0000, p2[k], (k == 7));
        end
        idle();

        // 4: back-to-back blocks, no idle cycle between them
        push("s4a", 16'h0001, 3, 16'h0000, 16'h0001, 1'b0);
        push("s4a", 16'h0002, 5, 16'hAAAA, 16'h0003, 1'b0);
        push("s4a", 16'h0004, 5, 16'hAAAA, 16'h0007, 1'b1);
        push("s4b", 16'h9249, 2, 16'hFFFF, 16'h6DB6, 1'b0);
        push("s4b", 16'h0001, 7, 16'h1234, 16'h6DB7, 1'b1);
        idle();

        // len==1: every word is its own block with its own seed
        push("l1", 16'h1234, 1, 16'h00FF, 16'h12CB, 1'b1);
        push("l1", 16'h0F0F, 1, 16'hF0F0, 16'hFFFF, 1'b1);
        chk("l1.busy", 32'(o_busy), 32'd0);
        idle();

        // 5: illegal length 0 runs MAX_WORDS words and sets the sticky error
        model = 16'h0000;
        for (int k = 0; k < MAX_WORDS; k++) begin
            model = model ^ WIDTH'(k * 16'h0101 + 1);
            push("s5", WIDTH'(k * 16'h0101 + 1), (k == 0) ? 0 : 2, 16'h0000, model, (k == MAX_WORDS - 1));
            if (k == 0) chk("s5.err_set", 32'(o_err_len), 32'd1);
        end
        idle();
        chk("s5.err_sticky", 32'(o_err_len), 32'd1);
        chk("s5.busy_after", 32'(o_busy),    32'd0);

        // 6: reset after the 4th accept discards the partial block
        push("s6", 16'h0001, 8, 16'h0000, 16'h0001, 1'b0);
        push("s6", 16'h0002, 8, 16'h0000, 16'h0003, 1'b0);
        push("s6", 16'h0003, 8, 16'h0000, 16'h0000, 1'b0);
        push("s6", 16'h0004, 8, 16'h0000, 16'h0004, 1'b0);
        chk("s6.busy_mid", 32'(o_busy), 32'd1);
        i_reset    = 1'b1;
        i_in_valid = 1'b1;
        #1;
        chk("s6.ready_in_rst", 32'(o_in_ready), 32'd0);
        tick();
        chk("s6.valid_rst", 32'(o_out_valid), 32'd0);
        chk("s6.busy_rst",  32'(o_busy),      32'd0);
        chk("s6.err_rst",   32'(o_err_len),   32'd0);
        i_reset    = 1'b0;
        i_in_valid = 1'b0;
        push("s6b", 16'h0005, 2, 16'h0000, 16'h0005, 1'b0);
        push("s6b", 16'h0006, 2, 16'h0000, 16'h0003, 1'b1);
        idle();
        chk("s6b.valid_after", 32'(o_out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
